fp_ftoi_seq: RTL and testbench
==============================

Name: fp_ftoi_seq

Overview:
- Multi-cycle converter from IEEE-754 single precision to signed 32-bit integer, with C-style round-toward-zero.
- Performs the float-to-integer conversion for the CPU's FP datapath. It consumes the same binary32 encoding the FP adder produces and hands integer results back to the integer register file.
- Uses an iterative shifter instead of a barrel shifter to save area.
- Valid/ready handshake on both input and output sides.

Parameters:
- SHIFT_PER_CYCLE, 1, bit positions the mantissa register shifts per SHIFT cycle. Legal values are 1, 2, 4 and 8; any other value is illegal.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  A is valid
- in_ready  output  1  converter can accept; high only in IDLE
- A  input  32  IEEE-754 single operand
- out_valid  output  1  Y and flags are valid
- out_ready  input  1  consumer accepts the result
- Y  output  32  signed two's-complement result
- invalid  output  1  NaN, infinity, or out-of-range input
- inexact  output  1  nonzero fraction bits were discarded

Behaviour:
- Reset, and any cycle with rst=1: state goes to IDLE; in_ready=1; out_valid=0; Y=0; invalid=0; inexact=0. Reset during SHIFT or DONE abandons the operation; no result is delivered.
- States: IDLE, SHIFT, DONE.
- IDLE: accept when in_valid && in_ready. Capture sign s, exponent e, and mag = {8'b0, 1'b1, A[22:0]}. Clear the sticky bit. Next state is selected by classification:
  - e==255: DONE. NaN (mantissa != 0) gives Y=32'h80000000. +inf gives 32'h7FFFFFFF; -inf gives 32'h80000000. invalid=1.
  - e<127 (covers zero and subnormals): DONE. Y=0. inexact = |A[30:0].
  - e>=158: DONE. If A==32'hCF000000, Y=32'h80000000 with invalid=0. Otherwise saturate: s=0 gives 7FFFFFFF, s=1 gives 80000000, invalid=1.
  - 127<=e<=157 with e==150: DONE directly, with n=0.
  - 127<=e<=157 otherwise: SHIFT. Shift count n=|e-150|. Direction is left if e>150 (n ≤ 7), right if e<150 (n ≤ 23).
- SHIFT: each cycle, shift mag by min(SHIFT_PER_CYCLE, remaining) and decrement remaining by the same amount.
  - On right shifts, OR every bit shifted out into sticky.
  - When remaining reaches 0, go to DONE.
  - SHIFT occupies ceil(n/SHIFT_PER_CYCLE) cycles.
- Entering DONE: Y = s ? -mag : mag. inexact = sticky. invalid=0 for the normal path.
- DONE: out_valid=1. Y and the flags are held stable until out_ready=1. On the handshake cycle, next state is IDLE and out_valid drops.
- in_ready=0 in SHIFT and DONE, so back-to-back operations are not overlapped.
- Latency from the accept edge to out_valid=1 is 1 + ceil(n/SHIFT_PER_CYCLE) cycles. It is exactly 1 for special, trivial and e==150 cases.
- -0.0 gives Y=0, inexact=0, invalid=0.
- No internal state changes while in DONE with out_ready=0.

Test Plan:
1. A=3F800000 (1.0), n=23, SHIFT_PER_CYCLE=1 -> out_valid 24 cycles after accept; Y=00000001, inexact=0, invalid=0.
2. A=C0490FDB (-3.14159) -> Y=FFFFFFFD, inexact=1, invalid=0. A=4EFFFFFF -> Y=7FFFFF80 after 1+7 cycles, inexact=0.
3. Range and specials, each with latency 1:
   - A=4F000000 -> Y=7FFFFFFF, invalid=1.
   - A=CF000000 -> Y=80000000, invalid=0.
   - A=7FC00000 -> Y=80000000, invalid=1.
   - A=FF800000 -> Y=80000000, invalid=1.
4. Small values:
   - A=3F000000 (0.5) -> Y=0, inexact=1.
   - A=80000000 -> Y=0, inexact=0.
   - A=00000001 (subnormal) -> Y=0, inexact=1.
   - A=4B000000 -> Y=00800000 with latency 1.
5. Backpressure and handshake:
   - Hold out_ready=0 for 5 cycles in DONE -> Y, flags and out_valid stay stable; in_ready=0.
   - Assert in_valid during SHIFT -> operand is ignored.
   - After the out_ready handshake, next cycle in_ready=1.
6. Reset mid-op: assert rst in SHIFT for 1 cycle -> next cycle in_ready=1, out_valid=0, Y=0. Then a fresh A=40000000 -> Y=00000002.

Source files
------------

// File: rtl/fp_ftoi_seq.sv
// fp_ftoi_seq: multi-cycle IEEE-754 binary32 to signed int32 converter with
// round-toward-zero. The mantissa is aligned by an iterative shifter that moves
// SHIFT_PER_CYCLE bit positions per cycle. Legal values are 1, 2, 4 and 8.
// Valid/ready handshakes are used on both sides, and only one operation is in flight.
module fp_ftoi_seq #(
   parameter int SHIFT_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] A,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] Y,
   output logic        invalid,
   output logic        inexact
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DONE
   } state_t;

   localparam logic [4:0]  LP_SPC     = 5'(SHIFT_PER_CYCLE);
   localparam logic [31:0] LP_INT_MAX = 32'h7FFF_FFFF;
   localparam logic [31:0] LP_INT_MIN = 32'h8000_0000;
   // -2^31 is the one operand at or above 2^31 in magnitude that is representable
   localparam logic [31:0] LP_NEG_2P31 = 32'hCF00_0000;

   state_t      r_state;
   logic        r_sign;
   logic        r_left;
   logic [31:0] r_mag;
   logic [4:0]  r_rem;
   logic        r_sticky;
   logic [31:0] r_y;
   logic        r_invalid;
   logic        r_inexact;

   logic [7:0]  w_exp;
   logic [31:0] w_mag_in;
   logic [4:0]  w_step;
   logic [31:0] w_mask;
   logic        w_lost;
   logic [31:0] w_mag_shifted;
   logic [4:0]  w_rem_next;

   // Handshake outputs decode straight from the state register
   assign in_ready  = (r_state == ST_IDLE);
   assign out_valid = (r_state == ST_DONE);
   assign Y         = r_y;
   assign invalid   = r_invalid;
   assign inexact   = r_inexact;

   assign w_exp    = A[30:23];
   assign w_mag_in = {8'b0, 1'b1, A[22:0]};

   // One step of the iterative shifter: min(SHIFT_PER_CYCLE, remaining) positions
   always_comb begin
      // NOTE: every always_comb output gets a value on every path (here unconditionally); otherwise a latch is inferred.
      w_step        = (r_rem < LP_SPC) ? r_rem : LP_SPC;
      w_mask        = ~(32'hFFFF_FFFF << w_step);
      w_lost        = |(r_mag & w_mask);
      w_mag_shifted = r_left ? (r_mag << w_step) : (r_mag >> w_step);
      w_rem_next    = r_rem - w_step;
   end

   // Control FSM and datapath registers; results are loaded on entry to DONE
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
      if (rst) begin
         // NOTE: datapath registers are plain flops, not a memory, so resetting them all is cheap and keeps Y at 0 after reset.
         r_state   <= ST_IDLE;
         r_sign    <= 1'b0;
         r_left    <= 1'b0;
         r_mag     <= '0;
         r_rem     <= '0;
         r_sticky  <= 1'b0;
         r_y       <= '0;
         r_invalid <= 1'b0;
         r_inexact <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_sign   <= A[31];
                  r_mag    <= w_mag_in;
                  r_sticky <= 1'b0;
                  if (w_exp == 8'hFF) begin
                     // NaN and -inf map to INT_MIN, +inf to INT_MAX
                     r_y       <= (A[31] || (|A[22:0])) ? LP_INT_MIN : LP_INT_MAX;
                     r_invalid <= 1'b1;
                     r_inexact <= 1'b0;
                     r_state   <= ST_DONE;
                  end else if (w_exp < 8'd127) begin
                     // |x| < 1 truncates to zero; any nonzero bit was a fraction
                     r_y       <= '0;
                     r_invalid <= 1'b0;
                     r_inexact <= |A[30:0];
                     r_state   <= ST_DONE;
                  end else if (w_exp >= 8'd158) begin
                     if (A == LP_NEG_2P31) begin
                        r_y       <= LP_INT_MIN;
                        r_invalid <= 1'b0;
                     end else begin
                        r_y       <= A[31] ? LP_INT_MIN : LP_INT_MAX;
                        r_invalid <= 1'b1;
                     end
                     r_inexact <= 1'b0;
                     r_state   <= ST_DONE;
                  end else if (w_exp == 8'd150) begin
                     // Mantissa is already integer-aligned
                     r_y       <= A[31] ? -w_mag_in : w_mag_in;
                     r_invalid <= 1'b0;
                     r_inexact <= 1'b0;
                     r_state   <= ST_DONE;
                  end else begin
                     r_left  <= (w_exp > 8'd150);
                     r_rem   <= (w_exp > 8'd150) ? 5'(w_exp - 8'd150) : 5'(8'd150 - w_exp);
                     r_state <= ST_SHIFT;
                  end
               end
            end

            ST_SHIFT: begin
               r_mag <= w_mag_shifted;
               r_rem <= w_rem_next;
               if (!r_left) begin
                  r_sticky <= r_sticky | w_lost;
               end
               if (w_rem_next == 5'd0) begin
                  r_y       <= r_sign ? -w_mag_shifted : w_mag_shifted;
                  r_invalid <= 1'b0;
                  r_inexact <= r_sticky | (!r_left && w_lost);
                  r_state   <= ST_DONE;
               end
            end

            ST_DONE: begin
               if (out_ready) begin
                  r_state <= ST_IDLE;
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_ftoi_seq.sv
// tb_fp_ftoi_seq: directed and random conversions against an arithmetic
// reference model, with latency, backpressure, input blocking and reset checks.
module tb_fp_ftoi_seq;

   localparam int SPC = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] A;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] Y;
   logic        invalid;
   logic        inexact;

   int n_checks = 0;
   int n_errors = 0;

   fp_ftoi_seq #(.SHIFT_PER_CYCLE(SPC)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Y         (Y),
      .invalid   (invalid),
      .inexact   (inexact)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: value = 1.f * 2^(e-127), truncated toward zero, with explicit range rules
   task automatic ref_model(input logic [31:0] a, output logic [31:0] y,
                            output logic inv, output logic inx, output int lat);
      logic        s;
      int          e;
      longint      m;
      longint      p;
      longint      mag;
      int          n;
      s   = a[31];
      e   = int'(a[30:23]);
      inv = 1'b0;
      inx = 1'b0;
      lat = 1;
      if (e == 255) begin
         inv = 1'b1;
         y   = (a[22:0] != 0 || s) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else if (e < 127) begin
         y   = 32'h0;
         inx = (a[30:0] != 0);
      end else if (e >= 158) begin
         if (a == 32'hCF00_0000) begin
            y = 32'h8000_0000;
         end else begin
            inv = 1'b1;
            y   = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
         end
      end else begin
         m = longint'(a[22:0]) + 64'd8388608;
         if (e >= 150) begin
            n   = e - 150;
            p   = 64'd1 << n;
            mag = m * p;
         end else begin
            n   = 150 - e;
            p   = 64'd1 << n;
            mag = m / p;
            inx = (m % p) != 0;
         end
         y   = s ? 32'(-mag) : 32'(mag);
         lat = 1 + (n + SPC - 1) / SPC;
      end
   endtask

   // One full transaction: accept, wait for result (poking in_valid meanwhile),
   // compare, optionally stall in DONE, then hand off and check in_ready returns
   task automatic do_op(input logic [31:0] a, input int stall, input string tag);
      logic [31:0] ey;
      logic        einv;
      logic        einx;
      int          elat;
      int          lat;
      logic [31:0] hy;
      logic [2:0]  hflags;
      ref_model(a, ey, einv, einx, elat);
      @(negedge clk);
      check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
      A        = a;
      in_valid = 1'b1;
      @(negedge clk);
      lat = 1;
      // Garbage operand held on the input while busy must be ignored
      A = $urandom;
      while (!out_valid && lat < 100) begin
         check({tag, ".busy_in_ready"}, 32'(in_ready), 32'd0);
         @(negedge clk);
         lat++;
         A = $urandom;
      end
      in_valid = 1'b0;
      check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
      if (!out_valid) begin
         $fatal(1, "FAIL %s.timeout: no out_valid within %0d cycles", tag, lat);
      end
      check({tag, ".latency"}, 32'(lat), 32'(elat));
      check({tag, ".Y"}, Y, ey);
      check({tag, ".invalid"}, 32'(invalid), 32'(einv));
      check({tag, ".inexact"}, 32'(inexact), 32'(einx));
      hy     = Y;
      hflags = {invalid, inexact, out_valid};
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check({tag, ".hold_Y"}, Y, hy);
         check({tag, ".hold_flags"}, 32'({invalid, inexact, out_valid}), 32'(hflags));
         check({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, ".post_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, ".post_in_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic [31:0] ra;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      A         = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("reset.in_ready", 32'(in_ready), 32'd1);
      check("reset.out_valid", 32'(out_valid), 32'd0);
      check("reset.Y", Y, 32'h0);
      check("reset.invalid", 32'(invalid), 32'd0);
      check("reset.inexact", 32'(inexact), 32'd0);

      do_op(32'h3F80_0000, 0, "one");
      do_op(32'hC049_0FDB, 0, "negpi");
      do_op(32'h4EFF_FFFF, 0, "maxleft");
      do_op(32'h4F00_0000, 0, "pos2p31");
      do_op(32'hCF00_0000, 0, "neg2p31");
      do_op(32'h7FC0_0000, 0, "nan");
      do_op(32'hFF80_0000, 0, "neginf");
      do_op(32'h7F80_0000, 0, "posinf");
      do_op(32'h3F00_0000, 0, "half");
      do_op(32'h8000_0000, 0, "negzero");
      do_op(32'h0000_0001, 0, "subnorm");
      do_op(32'h4B00_0000, 0, "e150");
      do_op(32'hCB7F_FFFF, 0, "e150neg");
      do_op(32'h3FFF_FFFF, 5, "stall");

      // Reset in the middle of SHIFT abandons the operation
      @(negedge clk);
      A        = 32'h3F80_0000;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst.in_ready", 32'(in_ready), 32'd1);
      check("midrst.out_valid", 32'(out_valid), 32'd0);
      check("midrst.Y", Y, 32'h0);
      do_op(32'h4000_0000, 0, "after_rst");

      // Random operands: half fully random, half steered into the shifting range
      for (int i = 0; i < 60; i++) begin
         ra = $urandom;
         if (i % 2 == 0) begin
            ra[30:23] = 8'(120 + $urandom_range(0, 40));
         end
         do_op(ra, (i % 7 == 0) ? 2 : 0, "rand");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
